// File: rtl/wave_pkg.sv
// Shared types and constants for the tt_um_waves configuration path:
// waveform encoding, ASCII command bytes, acknowledge bytes and controller states.
package wave_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        FIELD_WAVE    = 2'd0,
        FIELD_NOISE   = 2'd1,
        FIELD_FREQ    = 2'd2,
        FIELD_INVALID = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } ctrl_state_e;

    // One complete generator configuration, used for both staged and active copies.
    typedef struct packed {
        logic [1:0] wave;
        logic       noise;
        logic [3:0] freq;
    } wave_cfg_t;

    localparam logic [7:0] CMD_SINE       = 8'h57;  // 'W'
    localparam logic [7:0] CMD_SQUARE     = 8'h51;  // 'Q'
    localparam logic [7:0] CMD_TRI        = 8'h54;  // 'T'
    localparam logic [7:0] CMD_SAW        = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NOISE_ON   = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_NOISE_OFF  = 8'h46;  // 'F'
    localparam logic [7:0] CMD_FREQ_FIRST = 8'h41;  // 'A'
    localparam logic [7:0] CMD_FREQ_LAST  = 8'h50;  // 'P'

    localparam logic [7:0] ACK_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] ACK_ERR = 8'h3F;  // '?'

endpackage

// File: rtl/wave_cmd_decode.sv
// Combinational decoder from a received ASCII byte to the configuration
// field it targets and the value to write into that field.
module wave_cmd_decode
    import wave_pkg::*;
(
    input  logic [7:0] rx_data,
    output field_e     field_sel,
    output logic [3:0] field_val
);

    // 'F' and 'N' sit inside 'A'..'P' but are matched explicitly first, so they
    // never reach the frequency range and indices 5 and 13 stay unreachable.
    // The frequency index is the letter offset from 'A', taken on the low nibble
    // because 'A'..'P' spans exactly sixteen codes (0x41..0x50 wraps 1..0).
    always_comb begin
        field_sel = FIELD_INVALID;
        field_val = 4'd0;
        case (rx_data)
            CMD_SINE: begin
                field_sel = FIELD_WAVE;
                field_val = {2'b00, WAVE_SINE};
            end
            CMD_SQUARE: begin
                field_sel = FIELD_WAVE;
                field_val = {2'b00, WAVE_SQUARE};
            end
            CMD_TRI: begin
                field_sel = FIELD_WAVE;
                field_val = {2'b00, WAVE_TRI};
            end
            CMD_SAW: begin
                field_sel = FIELD_WAVE;
                field_val = {2'b00, WAVE_SAW};
            end
            CMD_NOISE_ON: begin
                field_sel = FIELD_NOISE;
                field_val = 4'd1;
            end
            CMD_NOISE_OFF: begin
                field_sel = FIELD_NOISE;
                field_val = 4'd0;
            end
            default: begin
                if ((rx_data >= CMD_FREQ_FIRST) && (rx_data <= CMD_FREQ_LAST)) begin
                    field_sel = FIELD_FREQ;
                    field_val = rx_data[3:0] - CMD_FREQ_FIRST[3:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/wave_cfg_ctrl.sv
// Configuration controller: decodes UART command bytes into staged waveform,
// noise and frequency settings and commits them to the generator only at a
// period wrap (or after a timeout) so the output never glitches mid-period.
// Every received byte is answered with an acknowledge byte.
module wave_cfg_ctrl
    import wave_pkg::*;
#(
    parameter int unsigned COMMIT_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       wrap_i,
    output logic [1:0] wave_sel,
    output logic       noise_en,
    output logic [3:0] freq_idx,
    output logic       cfg_update,
    output logic       pending,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic [7:0] err_count
);

    ctrl_state_e state;
    ctrl_state_e state_nxt;
    logic [31:0] timer;
    wave_cfg_t   stg;
    wave_cfg_t   stg_nxt;
    wave_cfg_t   act;
    field_e      cmd_field;
    logic [3:0]  cmd_val;
    logic        cmd_ok;
    logic        commit_go;

    wave_cmd_decode u_decode (
        .rx_data   (rx_data),
        .field_sel (cmd_field),
        .field_val (cmd_val)
    );

    assign cmd_ok = rx_valid && (cmd_field != FIELD_INVALID);

    // Staged view including this cycle's byte, so a byte arriving together with
    // the commit trigger is part of the committed configuration.
    always_comb begin
        stg_nxt = stg;
        if (cmd_ok) begin
            case (cmd_field)
                FIELD_WAVE:  stg_nxt.wave  = cmd_val[1:0];
                FIELD_NOISE: stg_nxt.noise = cmd_val[0];
                FIELD_FREQ:  stg_nxt.freq  = cmd_val;
                default:     stg_nxt       = stg;
            endcase
        end
    end

    // Next-state logic; commit_go marks the edge that loads the active outputs.
    always_comb begin
        state_nxt = state;
        commit_go = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_ok) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (wrap_i || (timer == COMMIT_TIMEOUT)) begin
                    state_nxt = ST_COMMIT;
                    commit_go = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_nxt = cmd_ok ? ST_PENDING : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout timer counts only while pending and restarts from zero on each entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= 32'd0;
        end else if (state == ST_PENDING) begin
            timer <= timer + 32'd1;
        end else begin
            timer <= 32'd0;
        end
    end

    // Staged configuration tracks every valid command; invalid bytes leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= stg_nxt;
        end
    end

    // Active configuration changes only on the commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act <= '0;
        end else if (commit_go) begin
            act <= stg_nxt;
        end
    end

    // Acknowledge register: newest response overwrites, handshake clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_data  <= 8'h00;
            ack_valid <= 1'b0;
        end else if (rx_valid) begin
            ack_data  <= cmd_ok ? ACK_OK : ACK_ERR;
            ack_valid <= 1'b1;
        end else if (ack_valid && ack_ready) begin
            ack_valid <= 1'b0;
        end
    end

    // Saturating count of rejected command bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (rx_valid && !cmd_ok && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign wave_sel   = act.wave;
    assign noise_en   = act.noise;
    assign freq_idx   = act.freq;
    assign cfg_update = (state == ST_COMMIT);
    assign pending    = (state == ST_PENDING);

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// Testbench for wave_cfg_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural reference.
module tb_wave_cfg_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wrap_i = 1'b0;
    logic       ack_ready = 1'b0;
    logic [1:0] wave_sel;
    logic       noise_en;
    logic [3:0] freq_idx;
    logic       cfg_update;
    logic       pending;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic [7:0] err_count;

    wave_cfg_ctrl #(.COMMIT_TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wrap_i     (wrap_i),
        .wave_sel   (wave_sel),
        .noise_en   (noise_en),
        .freq_idx   (freq_idx),
        .cfg_update (cfg_update),
        .pending    (pending),
        .ack_data   (ack_data),
        .ack_valid  (ack_valid),
        .ack_ready  (ack_ready),
        .err_count  (err_count)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    longint cyc = 0;

    // Reference state: active and staged configuration, pending window, ack and errors.
    int a_wave = 0, a_noise = 0, a_freq = 0;
    int s_wave = 0, s_noise = 0, s_freq = 0;
    bit m_pend = 0, m_upd = 0, m_ackv = 0;
    longint m_start = 0;
    int m_ackd = 0, m_err = 0;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Command table: kind 0 wave, 1 noise, 2 freq, 3 invalid.
    function automatic void ref_decode(input logic [7:0] b, output int kind, output int val);
        kind = 3;
        val  = 0;
        if (b == "W") begin kind = 0; val = 0; end
        else if (b == "Q") begin kind = 0; val = 1; end
        else if (b == "T") begin kind = 0; val = 2; end
        else if (b == "S") begin kind = 0; val = 3; end
        else if (b == "N") begin kind = 1; val = 1; end
        else if (b == "F") begin kind = 1; val = 0; end
        else if (b >= "A" && b <= "P") begin kind = 2; val = int'(b) - int'("A"); end
    endfunction

    task automatic model_step();
        int  kind, val;
        bit  ok, fire;
        if (!rst_n) begin
            a_wave = 0; a_noise = 0; a_freq = 0;
            s_wave = 0; s_noise = 0; s_freq = 0;
            m_pend = 0; m_upd = 0; m_ackv = 0; m_ackd = 0; m_err = 0;
        end else begin
            kind = 3;
            val  = 0;
            if (rx_valid) ref_decode(rx_data, kind, val);
            ok = rx_valid && (kind != 3);
            if (rx_valid) begin
                m_ackd = ok ? 'h4B : 'h3F;
                m_ackv = 1;
                if (!ok && m_err < 255) m_err++;
            end else if (m_ackv && ack_ready) begin
                m_ackv = 0;
            end
            if (ok) begin
                if (kind == 0) s_wave = val;
                else if (kind == 1) s_noise = val;
                else s_freq = val;
            end
            fire = m_pend && (wrap_i || (cyc - m_start == TIMEOUT));
            m_upd = 0;
            if (m_pend) begin
                if (fire) begin
                    a_wave = s_wave; a_noise = s_noise; a_freq = s_freq;
                    m_pend = 0;
                    m_upd  = 1;
                end
            end else if (ok) begin
                m_pend  = 1;
                m_start = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        checkOutput("wave_sel",   int'(wave_sel),   a_wave);
        checkOutput("noise_en",   int'(noise_en),   a_noise);
        checkOutput("freq_idx",   int'(freq_idx),   a_freq);
        checkOutput("cfg_update", int'(cfg_update), int'(m_upd));
        checkOutput("pending",    int'(pending),    int'(m_pend));
        checkOutput("ack_valid",  int'(ack_valid),  int'(m_ackv));
        checkOutput("ack_data",   int'(ack_data),   m_ackd);
        checkOutput("err_count",  int'(err_count),  m_err);
    endtask

    task automatic applyStimulus(input bit rst, input bit rv, input logic [7:0] rd,
                                 input bit wr, input bit rdy);
        rst_n     = rst;
        rx_valid  = rv;
        rx_data   = rd;
        wrap_i    = wr;
        ack_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 0, rdy);
    endtask

    function automatic logic [7:0] random_invalid();
        logic [7:0] b;
        int k, v;
        do begin
            b = 8'($urandom_range(0, 255));
            ref_decode(b, k, v);
        end while (k != 3);
        return b;
    endfunction

    initial begin
        int n, pulses;
        string pool;
        logic [7:0] rd;
        pool = "WQTSNFABCDEGHIJKLMOPxz?a";

        // Reset
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("reset_wave", int'(wave_sel), 0);
        checkOutput("reset_ack_data", int'(ack_data), 0);

        // 'T' stays staged until a wrap
        applyStimulus(1, 1, "T", 0, 0);
        checkOutput("T_ack", int'(ack_data), 'h4B);
        checkOutput("T_pending", int'(pending), 1);
        idle(4, 1);
        checkOutput("T_wave_hold", int'(wave_sel), 0);
        applyStimulus(1, 0, 8'h00, 1, 1);
        checkOutput("T_wave_commit", int'(wave_sel), 2);
        checkOutput("T_update", int'(cfg_update), 1);
        idle(2, 1);

        // Accumulated commands, single commit
        applyStimulus(1, 1, "S", 0, 1);
        applyStimulus(1, 1, "N", 0, 1);
        applyStimulus(1, 1, "C", 0, 1);
        idle(3, 1);
        pulses = 0;
        applyStimulus(1, 0, 8'h00, 1, 1);
        pulses += int'(cfg_update);
        for (int i = 0; i < 5; i++) begin
            idle(1, 1);
            pulses += int'(cfg_update);
        end
        checkOutput("SNC_wave", int'(wave_sel), 3);
        checkOutput("SNC_noise", int'(noise_en), 1);
        checkOutput("SNC_freq", int'(freq_idx), 2);
        checkOutput("SNC_update_pulses", pulses, 1);

        // Timeout commit
        applyStimulus(1, 1, "Q", 0, 1);
        n = 0;
        while (n < 60 && !cfg_update) begin
            idle(1, 1);
            n++;
        end
        checkOutput("timeout_latency", n, TIMEOUT + 1);
        checkOutput("timeout_wave", int'(wave_sel), 1);
        idle(2, 1);

        // Invalid bytes and err_count saturation
        applyStimulus(1, 1, "x", 0, 1);
        checkOutput("x_ack", int'(ack_data), 'h3F);
        checkOutput("x_pending", int'(pending), 0);
        for (int i = 0; i < 300; i++) applyStimulus(1, 1, random_invalid(), 0, 1);
        checkOutput("err_sat", int'(err_count), 255);
        applyStimulus(1, 0, 8'h00, 1, 1);
        checkOutput("inv_wave", int'(wave_sel), 1);
        checkOutput("inv_noise", int'(noise_en), 1);
        checkOutput("inv_freq", int'(freq_idx), 2);
        checkOutput("inv_no_update", int'(cfg_update), 0);

        // Newest response wins while transmitter is busy
        applyStimulus(1, 1, "W", 0, 0);
        applyStimulus(1, 1, "z", 0, 0);
        idle(3, 0);
        checkOutput("busy_ack_valid", int'(ack_valid), 1);
        checkOutput("busy_ack_data", int'(ack_data), 'h3F);
        idle(1, 1);
        checkOutput("ack_cleared", int'(ack_valid), 0);
        applyStimulus(1, 0, 8'h00, 1, 1);
        idle(2, 1);

        // Reset discards a staged change
        applyStimulus(1, 1, "P", 0, 0);
        idle(2, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        idle(1, 0);
        checkOutput("rst_freq", int'(freq_idx), 0);
        checkOutput("rst_pending", int'(pending), 0);
        checkOutput("rst_ack_valid", int'(ack_valid), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'h00, 1, 1);
            pulses += int'(cfg_update);
        end
        checkOutput("rst_no_update", pulses, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) rd = pool[$urandom_range(0, pool.len() - 1)];
            else rd = 8'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 99) < 30,
                          rd,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_cfg_ctrl.md
# wave_cfg_ctrl

Configuration controller between the UART receiver and the waveform datapath of `tt_um_waves`. It decodes single-byte ASCII commands into waveform, noise and frequency settings and stages them. Staged settings are committed to the generator only at a waveform period boundary, or after a timeout, so outputs never glitch mid-cycle. Every received byte gets an acknowledge byte for the host-side UART transmitter.

## Interface
- `COMMIT_TIMEOUT`, default 65535: cycles a pending configuration waits for `wrap_i` before it is force-committed.
- `clk`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle. It cannot be back-pressured.
- `wrap_i`  in  1  one-cycle pulse from the phase accumulator at period wrap.
- `wave_sel`  out  2  active waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- `noise_en`  out  1  active white-noise enable.
- `freq_idx`  out  4  active frequency index.
- `cfg_update`  out  1  one-cycle pulse in the cycle the active outputs change.
- `pending`  out  1  a staged configuration is awaiting commit.
- `ack_data`  out  8  response byte.
- `ack_valid`  out  1  response available.
- `ack_ready`  in  1  transmitter accepts `ack_data`.
- `err_count`  out  8  count of invalid command bytes, saturating.

## Operation
- Command map, case-sensitive:
  - 'W' (0x57) → sine
  - 'Q' (0x51) → square
  - 'T' (0x54) → triangle
  - 'S' (0x53) → sawtooth
  - 'N' (0x4E) → noise on
  - 'F' (0x46) → noise off
  - 'A'..'P' (0x41..0x50) → `freq_idx` 0..15
- Conflict: 'F' and 'N' are noise commands, never frequencies. 'Q' and 'S' fall outside 'A'..'P'. The frequency range is therefore 'A'..'P' minus 'F' and 'N'.
  - 'F' and 'N' keep their letter value in the index mapping, i.e. indices 5 and 13 are unreachable.
  - Any other byte, including lowercase, is invalid.
- Staged registers `stg_wave`, `stg_noise`, `stg_freq`:
  - A valid command overwrites only its own field.
  - Several commands before a commit accumulate, and a single commit applies them all.
- State machine:
  - **IDLE**: no pending change.
    - Valid byte → PENDING, timer cleared.
  - **PENDING**: timer increments each cycle.
    - `wrap_i`, or timer == `COMMIT_TIMEOUT` → COMMIT.
    - Further valid bytes update the staged fields and do not restart the timer.
  - **COMMIT**: one cycle.
    - Copy staged fields to the active outputs and pulse `cfg_update`.
    - Return to IDLE, or to PENDING if `rx_valid` carried a valid byte in this cycle.
- Acknowledge:
  - Valid byte → `ack_data` = 'K' (0x4B).
  - Invalid byte → '?' (0x3F), and `err_count` increments, saturating at 255.
  - Invalid bytes do not change state or staged fields.
- Ack handshake:
  - `ack_valid` rises with `ack_data` and holds until the cycle `ack_valid && ack_ready`, then clears.
  - A new response while `ack_valid` is already 1 replaces `ack_data`; `ack_valid` stays 1. The newest response wins.

## Timing
- Reset values:
  - `wave_sel` = 0 (sine), `noise_en` = 0, `freq_idx` = 0.
  - Staged fields equal the active values.
  - `cfg_update` = 0, `pending` = 0, `ack_valid` = 0, `ack_data` = 0x00, `err_count` = 0.
  - State IDLE, timer 0.
- Reset mid-operation discards any staged change and any outstanding ack.
- `rx_valid` at cycle N:
  - Staged field, `ack_data`/`ack_valid` and `pending` update at N+1.
- `wrap_i` seen at cycle M while PENDING:
  - COMMIT at M+1; active outputs and `cfg_update` change at the M+1 edge.
  - `pending` clears at M+1.
- `wrap_i` while IDLE is ignored.
- Same-cycle `rx_valid` and `wrap_i` in PENDING:
  - The byte is staged in this cycle and is included in the commit.
- Timeout: force commit occurs `COMMIT_TIMEOUT`+1 cycles after entering PENDING.
- `ack_ready` and a new response in the same cycle: the new response is loaded and `ack_valid` stays 1.

## Structure
- Shared package `wave_pkg` holds:
  - waveform enum: `WAVE_SINE`, `WAVE_SQUARE`, `WAVE_TRI`, `WAVE_SAW`;
  - ASCII command constants;
  - `ACK_OK` = 0x4B and `ACK_ERR` = 0x3F;
  - controller state enum.
- One sub-module, `wave_cmd_decode` (combinational), maps `rx_data` to:
  - field-select: wave / noise / freq / invalid;
  - field value.

## Test plan
- Reset, then send 'T':
  - `ack_data` = 0x4B and `pending` = 1.
  - `wave_sel` stays 0 until a `wrap_i` pulse.
  - One cycle after the pulse: `wave_sel` = 2 and one `cfg_update` pulse.
- Send 'S', 'N', 'C' with no wrap:
  - After one `wrap_i`: `wave_sel` = 3, `noise_en` = 1, `freq_idx` = 2.
  - Exactly one `cfg_update` pulse.
- `COMMIT_TIMEOUT` = 16, send 'Q' with no `wrap_i`:
  - `wave_sel` = 1 and `cfg_update` exactly 17 cycles after `pending` rises.
- Send 'x' (0x78), then 300 further invalid bytes:
  - `ack_data` = 0x3F.
  - `err_count` saturates at 255.
  - Active and staged configuration unchanged.
- Hold `ack_ready` = 0, send 'W' then 'z':
  - `ack_valid` stays 1 and `ack_data` = 0x3F.
  - Raise `ack_ready` for one cycle: `ack_valid` = 0 next cycle.
- Send 'P', assert `rst_n` = 0 before any wrap:
  - After reset, `freq_idx` = 0, `pending` = 0, `ack_valid` = 0.
  - A later `wrap_i` produces no `cfg_update`.
